ufm_acc: RTL and testbench



---
 rtl/ufm_pkg.sv | 28 ++
 rtl/ufm_acc.sv | 139 +++++++++++++
 tb/tb_ufm_acc.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ufm_pkg.sv
// ---------------------------------------------------------------------------
// ufm_pkg
// Constants and types shared between the unsigned fixed-width multiplier
// (ufm) and its downstream accumulator (ufm_acc).
//   OPW         : operand width of each ufm input.
//   PW_DEF      : default product width (2 x OPW).
//   N_TERMS_DEF : default number of products per vector.
//   acc_state_t : accumulator FSM state encoding.
//   min_aw()    : smallest accumulator width that cannot wrap for a vector.
// ---------------------------------------------------------------------------
package ufm_pkg;

   localparam int OPW         = 3;
   localparam int PW_DEF      = 2 * OPW;
   localparam int N_TERMS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

   // A sum of n products of pw bits each needs pw + ceil(log2(n)) bits.
   function automatic int min_aw(input int pw, input int n_terms);
      return pw + $clog2(n_terms);
   endfunction

endpackage

// File: rtl/ufm_acc.sv
// ---------------------------------------------------------------------------
// ufm_acc
// Accumulates up to N_TERMS unsigned products from the ufm multiplier into a
// dot-product sum, then offers sum, term count and overflow flag downstream.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous abort, drops the partial vector
//   in_valid   : product available
//   in_ready   : block accepts a product this cycle (not in DONE)
//   in_data    : unsigned product, PW bits
//   in_last    : current product ends the vector early
//   out_valid  : result available
//   out_ready  : consumer takes the result
//   out_sum    : accumulated sum modulo 2^AW
//   out_count  : number of terms in out_sum
//   out_ovf    : carry out of bit AW-1 occurred during this vector
// ---------------------------------------------------------------------------
module ufm_acc
   import ufm_pkg::*;
#(
   parameter int PW      = PW_DEF,
   parameter int AW      = 8,
   parameter int N_TERMS = N_TERMS_DEF,
   parameter int CW      = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic [CW-1:0] out_count,
   output logic          out_ovf
);

   // Zero-extending AW+1 bit add; bit AW is the carry out of the accumulator.
   function automatic logic [AW:0] add_carry(input logic [AW-1:0] a,
                                             input logic [PW-1:0] b);
      return {1'b0, a} + (AW+1)'(b);
   endfunction

   acc_state_t    state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;

   logic          accept;
   logic          take;
   logic [AW:0]   sum_ext;
   logic [CW-1:0] cnt_inc;

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;
   assign sum_ext   = add_carry(acc_q, in_data);
   assign cnt_inc   = cnt_q + CW'(1);

   // The result registers double as the output holding registers: nothing
   // writes them in DONE except a take, so they stay stable under backpressure.
   assign out_sum   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   // Next-state and accumulator update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      if (clear) begin
         // Abort wins over everything, including a product offered this cycle.
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  acc_d   = AW'(in_data);
                  cnt_d   = CW'(1);
                  ovf_d   = 1'b0;
                  state_d = (in_last || (N_TERMS == 1)) ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_d = sum_ext[AW-1:0];
                  ovf_d = ovf_q | sum_ext[AW];
                  cnt_d = cnt_inc;
                  if (in_last || (cnt_inc == CW'(N_TERMS))) begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               // in_ready is low here, so in_data/in_last are ignored; the
               // earliest new accept is the cycle after the take.
               if (take) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   // State and accumulator registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ufm_acc.sv
// ---------------------------------------------------------------------------
// tb_ufm_acc
// Directed bench for ufm_acc. Two instances run in lockstep on the same
// stimulus: u_dut with default widths (AW=8) and u_dut7 with AW=7, so the
// wrap/overflow behaviour can be compared against a non-wrapping reference.
// ---------------------------------------------------------------------------
module tb_ufm_acc;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       in_valid;
   logic [5:0] in_data;
   logic       in_last;
   logic       out_ready;

   logic       rdy_a, vld_a, ovf_a;
   logic [7:0] sum_a;
   logic [2:0] cnt_a;

   logic       rdy_b, vld_b, ovf_b;
   logic [6:0] sum_b;
   logic [2:0] cnt_b;

   int n_chk;
   int n_pass;

   ufm_acc u_dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (rdy_a),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (vld_a),
      .out_ready (out_ready),
      .out_sum   (sum_a),
      .out_count (cnt_a),
      .out_ovf   (ovf_a)
   );

   ufm_acc #(.AW(7)) u_dut7 (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (rdy_b),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (vld_b),
      .out_ready (out_ready),
      .out_sum   (sum_b),
      .out_count (cnt_b),
      .out_ovf   (ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, got running, need finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Offers the products back to back with in_valid held high; returns #1
   // after the edge that accepted the final term.
   task automatic send_vec(input int v[], input bit last_on_final);
      foreach (v[i]) begin
         in_valid = 1'b1;
         in_data  = 6'(v[i]);
         in_last  = last_on_final && (i == v.size() - 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // One cycle with out_ready high: take happens, then IDLE is visible.
   task automatic take_cycle(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_vld_after_take"}, vld_a, 0);
      chk({tag, "_rdy_after_take"}, rdy_a, 1);
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rst       = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // reset state
      #1;
      chk("rst_vld", vld_a, 0);
      chk("rst_rdy", rdy_a, 1);
      chk("rst_sum", sum_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_ovf", ovf_a, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: defaults, 10+14+0+7
      send_vec('{10, 14, 0}, 0);
      chk("t1_vld_before_last", vld_a, 0);
      send_vec('{7}, 0);
      chk("t1_vld", vld_a, 1);
      chk("t1_sum", sum_a, 31);
      chk("t1_cnt", cnt_a, 4);
      chk("t1_ovf", ovf_a, 0);
      chk("t1_rdy_done", rdy_a, 0);
      take_cycle("t1");

      // 2: overflow on AW=7, none on AW=8
      send_vec('{63, 63, 63, 63}, 0);
      chk("t2_sum7", sum_b, 124);
      chk("t2_ovf7", ovf_b, 1);
      chk("t2_sum8", sum_a, 252);
      chk("t2_ovf8", ovf_a, 0);
      take_cycle("t2");
      send_vec('{1, 1, 1, 1}, 0);
      chk("t2b_sum7", sum_b, 4);
      chk("t2b_ovf7", ovf_b, 0);
      chk("t2b_cnt7", cnt_b, 4);
      take_cycle("t2b");

      // 3: early termination
      send_vec('{10, 14}, 1);
      chk("t3_vld", vld_a, 1);
      chk("t3_sum", sum_a, 24);
      chk("t3_cnt", cnt_a, 2);
      take_cycle("t3");

      // 4: backpressure, product offered during hold must be ignored
      out_ready = 1'b0;
      send_vec('{5, 5, 5, 5}, 0);
      chk("t4_vld", vld_a, 1);
      chk("t4_sum", sum_a, 20);
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = 6'd33;
         in_last  = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("t4_hold%0d_vld", k), vld_a, 1);
         chk($sformatf("t4_hold%0d_sum", k), sum_a, 20);
         chk($sformatf("t4_hold%0d_cnt", k), cnt_a, 4);
         chk($sformatf("t4_hold%0d_rdy", k), rdy_a, 0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      take_cycle("t4");
      send_vec('{1, 2}, 1);
      chk("t4_next_sum", sum_a, 3);
      chk("t4_next_cnt", cnt_a, 2);
      take_cycle("t4n");

      // 5: clear drops partial vector and the product offered with it
      send_vec('{9, 9}, 0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 6'd9;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t5_clr_vld", vld_a, 0);
      chk("t5_clr_rdy", rdy_a, 1);
      chk("t5_clr_sum", sum_a, 0);
      chk("t5_clr_cnt", cnt_a, 0);
      send_vec('{1, 2, 3, 4}, 0);
      chk("t5_sum", sum_a, 10);
      chk("t5_cnt", cnt_a, 4);
      take_cycle("t5");

      // 6: asynchronous reset between edges
      send_vec('{20, 30}, 0);
      chk("t6_partial", sum_a, 50);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_vld", vld_a, 0);
      chk("t6_rst_rdy", rdy_a, 1);
      chk("t6_rst_sum", sum_a, 0);
      chk("t6_rst_cnt", cnt_a, 0);
      #2 rst = 1'b0;
      send_vec('{2, 2, 2, 2}, 0);
      chk("t6_vld", vld_a, 1);
      chk("t6_sum", sum_a, 8);
      chk("t6_cnt", cnt_a, 4);
      take_cycle("t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
